// File: rtl/frame_buffer_reader_if.sv
// Bus bundle for frame_buffer_reader: Avalon-MM read master side
// and Avalon-ST RGB pixel stream side.
interface frame_buffer_reader_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_waitrequest;
    logic [31:0]       m_readdata;
    logic              m_readdatavalid;
    logic [23:0]       st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        output m_address, m_read,
        input  m_waitrequest, m_readdata, m_readdatavalid,
        output st_data, st_valid, st_sop, st_eop,
        input  st_ready
    );

    modport slave (
        input  m_address, m_read,
        output m_waitrequest, m_readdata, m_readdatavalid,
        input  st_data, st_valid, st_sop, st_eop,
        output st_ready
    );
endinterface

// File: rtl/frame_buffer_reader.sv
// Frame buffer reader: Avalon-MM read master feeding a pixel FIFO
// that drives an Avalon-ST RGB stream with sop/eop framing.
module frame_buffer_reader #(
    parameter int ADDR_W     = 32,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [ADDR_W-1:0]     buffer_base,
    frame_buffer_reader_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underflow
);

    localparam int N  = H_RES * V_RES;
    localparam int CW = $clog2(N + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] N_TOTAL = CW'(N);
    localparam logic [CW-1:0] N_LAST  = CW'(N - 1);
    localparam logic [FW:0]   DEPTH_C = (FW + 1)'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_issued;
    logic [CW-1:0]     r_popped;
    logic [FW-1:0]     r_out;
    logic [FW-1:0]     r_count;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [23:0]       r_mem [FIFO_DEPTH];
    logic              r_underflow;

    logic          w_read;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_last;
    logic          w_done;
    logic          w_start;
    logic          w_under;
    logic [FW:0]   w_credit;
    logic          w_unused;

    assign w_unused = ^bus.m_readdata[31:24];

    assign w_empty  = (r_count == '0);
    assign w_push   = bus.m_readdatavalid && (r_state == S_RUN);
    assign w_pop    = !w_empty && bus.st_ready;
    assign w_last   = (r_popped == N_LAST);
    assign w_done   = w_pop && w_last;
    assign w_start  = enable && ((r_state == S_IDLE) || w_done);
    assign w_issue  = w_read && !bus.m_waitrequest;
    // Reads in flight plus buffered words never exceed the FIFO size
    assign w_credit = {1'b0, r_count} + {1'b0, r_out};
    assign w_under  = (r_state == S_RUN) && (r_popped != '0) &&
                      (r_popped < N_TOTAL) && bus.st_ready && w_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (enable) w_next = S_RUN;
            S_RUN:  if (w_done && !enable) w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        w_read = 1'b0;
        unique case (r_state)
            S_IDLE: ;
            S_RUN: begin
                busy   = 1'b1;
                w_read = (r_issued < N_TOTAL) && (w_credit < DEPTH_C);
            end
        endcase
        frame_done = w_done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_issued    <= '0;
            r_popped    <= '0;
            r_out       <= '0;
            r_underflow <= 1'b0;
        end else if (w_start) begin
            r_addr      <= buffer_base;
            r_issued    <= '0;
            r_popped    <= '0;
            r_out       <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_issue) begin
                r_addr   <= r_addr + ADDR_W'(4);
                r_issued <= r_issued + CW'(1);
            end
            if (w_pop) r_popped <= r_popped + CW'(1);
            r_out <= r_out + FW'(w_issue) - FW'(w_push);
            if (w_under) r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop)  r_rp <= r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FW'(1);
                2'b01:   r_count <= r_count - FW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= bus.m_readdata[23:0];
    end

    assign bus.m_read    = w_read;
    assign bus.m_address = r_addr;
    assign bus.st_valid  = !w_empty;
    assign bus.st_data   = w_empty ? 24'h0 : r_mem[r_rp];
    assign bus.st_sop    = !w_empty && (r_popped == '0);
    assign bus.st_eop    = !w_empty && w_last;
    assign underflow     = r_underflow;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Directed bench for frame_buffer_reader: 2-cycle-latency memory model
// with scripted stalls and a scoreboard of expected reads and pixels.
module tb_frame_buffer_reader;

    localparam int AW = 32;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int D  = 4;
    localparam int N  = H * V;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [AW-1:0] buffer_base;
    logic          busy;
    logic          frame_done;
    logic          underflow;

    frame_buffer_reader_if #(.ADDR_W(AW)) bus ();

    frame_buffer_reader #(
        .ADDR_W(AW), .H_RES(H), .V_RES(V), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .buffer_base(buffer_base),
        .bus(bus),
        .busy(busy),
        .frame_done(frame_done),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] exp_addr [$];
    logic [25:0] exp_pix  [$];

    int stall_fr, stall_idx, stall_len;
    int stall_served, stall_left, stall_cycles;
    bit stalling;
    bit pv0, pv1;
    logic [31:0] pa0, pa1;
    int rd_in_frame, fr_cnt;
    int inflight, max_inflight;
    int pix_in_frame, done_cnt;
    bit chk_restart;
    logic [31:0] restart_base;
    bit prev_hold;
    logic [23:0] prev_data;
    logic prev_sop, prev_eop;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] pix(logic [31:0] a);
        return 24'h112233 + a[23:0] - 24'h001000;
    endfunction

    task automatic push_frame(logic [31:0] base);
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back(base + 32'(4 * i));
            exp_pix.push_back({(i == N - 1), (i == 0), pix(base + 32'(4 * i))});
        end
    endtask

    task automatic wait_done(int target, int limit);
        int k = 0;
        while (done_cnt < target && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        check("frames_done", done_cnt, target);
    endtask

    task automatic wait_pix(int target, int limit);
        int k = 0;
        while (pix_in_frame < target && k < limit) begin
            @(posedge clk); #1;
            k++;
        end
        check("pixels_reached", (pix_in_frame >= target) ? 1 : 0, 1);
    endtask

    // Memory model and stream monitor, evaluated mid-cycle
    always @(negedge clk) begin
        if (!reset_n) begin
            bus.m_waitrequest   = 1'b0;
            bus.m_readdatavalid = 1'b0;
            bus.m_readdata      = 32'h0;
            pv0 = 0; pv1 = 0; pa0 = '0; pa1 = '0;
            rd_in_frame = 0; fr_cnt = 0;
            stalling = 0; stall_left = 0; stall_served = -1;
            inflight = 0; pix_in_frame = 0;
            chk_restart = 0; prev_hold = 0;
            exp_addr.delete();
            exp_pix.delete();
        end else begin
            logic        acc;
            logic [31:0] aa;
            logic [31:0] a_exp;
            logic [25:0] e;
            logic        exp_e;
            if (chk_restart) begin
                check("restart_read", bus.m_read, 1);
                check("restart_addr", bus.m_address, restart_base);
                chk_restart = 0;
            end
            if (!stalling && bus.m_read && fr_cnt == stall_fr &&
                rd_in_frame == stall_idx && stall_served != stall_fr) begin
                stalling = 1;
                stall_left = stall_len;
                stall_served = stall_fr;
            end
            if (stalling) begin
                bus.m_waitrequest = 1'b1;
                check("stall_read", bus.m_read, 1);
                check("stall_addr", bus.m_address,
                      (exp_addr.size() != 0) ? exp_addr[0] : 32'hFFFF_FFFF);
                stall_cycles++;
                stall_left--;
                if (stall_left == 0) stalling = 0;
            end else begin
                bus.m_waitrequest = 1'b0;
            end
            acc = bus.m_read && !bus.m_waitrequest;
            aa  = bus.m_address;
            if (acc) begin
                a_exp = (exp_addr.size() != 0) ? exp_addr.pop_front() : 32'hFFFF_FFFF;
                check("read_addr", aa, a_exp);
                rd_in_frame++;
                if (rd_in_frame == N) begin
                    rd_in_frame = 0;
                    fr_cnt++;
                end
                inflight++;
            end
            bus.m_readdatavalid = pv1;
            bus.m_readdata      = pv1 ? {8'hAA, pix(pa1)} : 32'h0;
            pv1 = pv0; pa1 = pa0;
            pv0 = acc; pa0 = aa;

            if (prev_hold) begin
                check("hold_valid", bus.st_valid, 1);
                check("hold_data", bus.st_data, prev_data);
                check("hold_sop", bus.st_sop, prev_sop);
                check("hold_eop", bus.st_eop, prev_eop);
            end
            exp_e = 1'b0;
            if (bus.st_valid && bus.st_ready) begin
                e = (exp_pix.size() != 0) ? exp_pix.pop_front() : '1;
                check("pix_data", bus.st_data, e[23:0]);
                check("pix_sop", bus.st_sop, e[24]);
                check("pix_eop", bus.st_eop, e[25]);
                exp_e = e[25];
                inflight--;
                pix_in_frame++;
            end
            if ((bus.st_valid && bus.st_ready) || frame_done)
                check("frame_done", frame_done, exp_e);
            if (frame_done) begin
                done_cnt++;
                pix_in_frame = 0;
                if (enable) begin
                    push_frame(buffer_base);
                    chk_restart = 1;
                    restart_base = buffer_base;
                end
            end
            prev_hold = bus.st_valid && !bus.st_ready;
            prev_data = bus.st_data;
            prev_sop  = bus.st_sop;
            prev_eop  = bus.st_eop;
            if (inflight > max_inflight) max_inflight = inflight;
        end
    end

    initial begin
        reset_n = 1'b0;
        enable = 1'b0;
        buffer_base = 32'h1000;
        bus.st_ready = 1'b1;
        stall_fr = 1; stall_idx = 2; stall_len = 5;
        stall_cycles = 0; max_inflight = 0; done_cnt = 0;
        @(posedge clk); #1;
        check("rst_m_read", bus.m_read, 0);
        check("rst_m_address", bus.m_address, 0);
        check("rst_st_valid", bus.st_valid, 0);
        check("rst_st_data", bus.st_data, 0);
        check("rst_st_sop", bus.st_sop, 0);
        check("rst_st_eop", bus.st_eop, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_underflow", underflow, 0);
        #2 reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("idle_busy", busy, 0);
        check("idle_read", bus.m_read, 0);

        push_frame(32'h1000);
        enable = 1'b1;
        repeat (3) @(posedge clk); #1;
        buffer_base = 32'h3000;
        wait_done(1, 200);
        buffer_base = 32'h5000;
        wait_done(2, 200);
        check("stall_cycles_b", stall_cycles, 5);

        bus.st_ready = 1'b0;
        stall_fr = 3; stall_idx = 3; stall_len = 10;
        repeat (40) @(posedge clk); #1;
        check("fill_inflight", inflight, D);
        check("fill_read", bus.m_read, 0);
        check("fill_sop", bus.st_sop, 1);
        check("fill_data", bus.st_data, pix(32'h5000));
        bus.st_ready = 1'b1;
        buffer_base = 32'h7000;
        wait_done(3, 200);

        buffer_base = 32'hB000;
        wait_pix(2, 50);
        check("under_early", underflow, 0);
        repeat (10) @(posedge clk); #1;
        check("under_set", underflow, 1);
        wait_pix(6, 100);
        check("under_sticky", underflow, 1);
        wait_done(4, 200);
        check("under_clear", underflow, 0);

        wait_pix(3, 100);
        enable = 1'b0;
        wait_done(5, 200);
        check("end_busy", busy, 0);
        check("end_read", bus.m_read, 0);
        check("end_valid", bus.st_valid, 0);
        @(posedge clk); #1;
        check("idle2_busy", busy, 0);
        check("addr_queue_empty", exp_addr.size(), 0);
        check("pix_queue_empty", exp_pix.size(), 0);
        check("stall_cycles_d", stall_cycles, 15);
        check("max_inflight_ok", (max_inflight <= D) ? 1 : 0, 1);

        buffer_base = 32'h9000;
        push_frame(32'h9000);
        enable = 1'b1;
        wait_pix(2, 50);
        #2 reset_n = 1'b0;
        #1;
        check("arst_m_read", bus.m_read, 0);
        check("arst_m_address", bus.m_address, 0);
        check("arst_st_valid", bus.st_valid, 0);
        check("arst_st_data", bus.st_data, 0);
        check("arst_st_sop", bus.st_sop, 0);
        check("arst_st_eop", bus.st_eop, 0);
        check("arst_busy", busy, 0);
        check("arst_frame_done", frame_done, 0);
        check("arst_underflow", underflow, 0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("post_busy", busy, 0);
        check("post_read", bus.m_read, 0);
        check("post_valid", bus.st_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/frame_buffer_reader.md
Name: frame_buffer_reader

Overview:
- Avalon-MM read master that fetches one frame of 32-bit pixel words from a frame buffer in SDRAM/DDR3.
- Converts the words into an Avalon-ST RGB pixel stream with packet framing, feeding the VGA output path inside the system.
- Acts as the consumer of the frame buffer that the HPS writes.
- Buffers reads in an internal FIFO, so memory latency and waitrequest stalls are absorbed ahead of the pixel-clock-domain consumer.

Parameters:
- ADDR_W, 32: Avalon byte-address width.
- H_RES, 640: pixels per line.
- V_RES, 480: lines per frame.
- FIFO_DEPTH, 32: pixel FIFO entries (power of 2, >=4).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = fetch frames continuously
buffer_base  in  ADDR_W  byte address of frame start; sampled at frame start only
m_address  out  ADDR_W  Avalon-MM read address (byte, word-aligned)
m_read  out  1  Avalon-MM read request
m_waitrequest  in  1  slave stall
m_readdata  in  32  read data, pixel in [23:0] = {R[7:0],G[7:0],B[7:0]}, [31:24] ignored
m_readdatavalid  in  1  read data valid (pipelined reads, in order)
st_data  out  24  pixel {R,G,B}
st_valid  out  1  stream valid
st_ready  in  1  stream ready
st_sop  out  1  high with first pixel of frame
st_eop  out  1  high with last pixel of frame
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse when last pixel accepted
underflow  out  1  sticky: consumer ready while FIFO empty mid-frame

Behaviour:
- Reset values (async, reset_n=0): m_address=0, m_read=0, st_data=0, st_valid=0, st_sop=0, st_eop=0, busy=0, frame_done=0, underflow=0. FIFO, counters and outstanding count cleared; state=IDLE.
- N = H_RES*V_RES. Counters: issued, returned, popped. Width is clog2(N+1). Outstanding = issued - returned. The outstanding count also has width clog2(FIFO_DEPTH+1).
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - On an edge where enable=1: latch base_q=buffer_base, clear all counters and underflow, go to RUN.
  - m_read=1 with m_address=base_q from the next cycle.
- RUN (busy=1), read side:
  - Read issued (m_read=1) when issued<N and fifo_count+outstanding<FIFO_DEPTH.
  - While m_waitrequest=1, m_read and m_address are held stable.
  - A read counts as issued on a cycle with m_read=1 and m_waitrequest=0. m_address then advances by 4.
  - No read is ever issued that could overflow the FIFO.
- RUN, return side:
  - m_readdatavalid=1 writes m_readdata[23:0] into the FIFO and increments returned.
  - The FIFO is never written when full; this is guaranteed by the credit rule above.
- Stream side:
  - st_valid = FIFO not empty. st_data = FIFO head.
  - First-word latency: readdatavalid in cycle k gives st_valid=1 in cycle k+1.
  - Pop on st_valid & st_ready. st_data, st_sop and st_eop are stable while st_valid=1 and st_ready=0.
  - st_sop=1 iff popped==0. st_eop=1 iff popped==N-1.
- Underflow: in RUN with popped in 1..N-1, st_ready=1 and FIFO empty sets underflow=1. It stays set until the next frame start.
- Frame end:
  - The cycle the EOP pixel is popped, frame_done=1 for exactly 1 cycle.
  - If enable=1 that cycle: re-latch buffer_base, clear counters, stay in RUN. The next frame's first read is issued the following cycle (no dead frame).
  - Otherwise go to IDLE.
- Deasserting enable mid-frame does not abort; the current frame completes, including all EOP handshakes.
- Changes to buffer_base mid-frame have no effect until the next frame start.
- Simultaneous FIFO push and pop in the same cycle: count unchanged, both take effect.
- A reset mid-frame discards all in-flight state. The system guarantees no readdatavalid arrives for pre-reset reads after reset_n rises.

Test Plan:
- H_RES=4, V_RES=2, enable=1, base=0x1000, zero-wait memory with 2-cycle read latency, st_ready=1 -> addresses 0x1000..0x101C issued once each in order. 8 pixels out with sop on pixel 0 and eop on pixel 7. frame_done pulses once, and the next frame's read to the newly sampled base starts the following cycle.
- m_waitrequest=1 for 5 cycles on the 3rd read -> m_address=0x1008 and m_read held stable all 5 cycles. No duplicate or skipped address.
- st_ready=0 for 40 cycles with FIFO_DEPTH=4 -> at most 4 reads outstanding+buffered, no FIFO overflow. On release, pixels are delivered in order with no loss.
- Pattern data 0xAA112233 -> st_data=0x112233; the top byte is dropped.
- enable dropped at pixel 3 of 8 -> frame completes through eop, frame_done pulses, then IDLE with busy=0 and m_read=0.
- st_ready=1 and memory stalled 10 cycles after pixel 2 -> underflow=1, and it stays set until the next frame start. Async reset asserted mid-frame -> all outputs return to their reset values immediately.
